linear_image_filter_sdiv_seq: RTL and testbench
===============================================

LINEAR_IMAGE_FILTER_SDIV_SEQ -- requirements
Module: linear_image_filter_sdiv_seq

Interface
REQ-001 The module SHALL have parameter din0_WIDTH, default 32, dividend width.
REQ-002 The module SHALL have parameter din1_WIDTH, default 32, divisor width; it equals din0_WIDTH.
REQ-003 The module SHALL have parameter dout_WIDTH, default 32, quotient/remainder width; it equals din0_WIDTH (W below).
REQ-004 The module SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The module SHALL have port ce, input, 1, clock enable; when low, all state is frozen.
REQ-007 The module SHALL have port start, input, 1, request to begin a division.
REQ-008 The module SHALL have port din0, input, W, signed dividend.
REQ-009 The module SHALL have port din1, input, W, signed divisor.
REQ-010 The module SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 The module SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-012 The module SHALL have port quotient, output, W, signed quotient.
REQ-013 The module SHALL have port remainder, output, W, signed remainder.
REQ-014 The module SHALL have port div_by_zero, output, 1, set with done when din1 was zero.

Function
REQ-015 The module SHALL use states IDLE, CALC and FIX.
REQ-016 In IDLE, with ce=1 and start=1, the module SHALL capture |din0|, |din1|, both signs and a zero-divisor flag, load the iteration counter with W, and enter CALC; busy SHALL be 1 from the next cycle.
REQ-017 In CALC, each ce=1 edge SHALL perform one radix-2 restoring step: shift the partial remainder left with the next dividend MSB, subtract |divisor| if no borrow, and shift the result bit into the quotient; the counter SHALL decrement.
REQ-018 After exactly W CALC steps, the module SHALL enter FIX.
REQ-019 In FIX, with ce=1, the module SHALL apply the signs, register quotient/remainder, assert done for one cycle, clear busy and return to IDLE.
REQ-020 Latency SHALL be fixed: with start accepted at edge T0 and ce held high, done SHALL be high in the cycle after edge T0+W+1 (edge 33 for W=32), independent of operand values.
REQ-021 Each cycle with ce=0 SHALL delay done by exactly one cycle.
REQ-022 Division SHALL truncate toward zero: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-023 Magnitudes SHALL be computed in W+1 bits so that the minimum negative value is handled.
REQ-024 The case MIN/-1 SHALL yield quotient = MIN (two's-complement wrap) and remainder 0, with no flag.
REQ-025 With divisor 0, the module SHALL skip sign correction and produce quotient all-ones and remainder = original din0, with div_by_zero=1 during done and the same latency.
REQ-026 Start asserted while busy SHALL be ignored, with no effect on the running operation.
REQ-027 Start asserted in the cycle done is high SHALL be accepted, allowing back-to-back operations every W+2 cycles.
REQ-028 quotient, remainder and div_by_zero SHALL hold their values until the next FIX.

Reset
REQ-029 Reset SHALL force IDLE immediately; busy, done, div_by_zero, quotient, remainder and the counter SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort it: no done is produced, and the first start after reset deasserts behaves per REQ-016.
REQ-031 Reset SHALL take effect regardless of ce.

Verification
REQ-032 The bench SHALL check: 100 / 7, ce=1 -> done at edge 33, quotient 14, remainder 2, div_by_zero 0; busy high for cycles 1-32.
REQ-033 The bench SHALL check sign combinations: -100/7 -> -14 r -2; 100/-7 -> -14 r 2; -100/-7 -> 14 r -2.
REQ-034 The bench SHALL check boundary operands: 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1; 0x80000000/-1 -> quotient 0x80000000, remainder 0.
REQ-035 The bench SHALL check ce stalls: 1000/10 with ce low for 10 cycles mid-CALC -> done at edge 43, quotient 100, remainder 0; start pulses during busy are ignored.
REQ-036 The bench SHALL check reset and back-to-back operation: reset at cycle 15 of a division -> outputs 0 and no done; then back-to-back starts 7/2 and -9/4 -> results 3 r 1 and -2 r -1, with done pulses 34 cycles apart.

Source files
------------

// File: rtl/linear_image_filter_sdiv_seq.sv
// Sequential signed divider: radix-2 restoring core on W+1-bit magnitudes,
// fixed latency of W+2 cycles per operation, truncating toward zero.
module linear_image_filter_sdiv_seq #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quotient,
  output logic [dout_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int W  = din0_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  // Dividend magnitude shifts out the top while quotient bits shift in below.
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W:0]    dsr_q, dsr_d;
  logic          sign0_q, sign0_d, sign1_q, sign1_d, zero_q, zero_d;
  logic          busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [W-1:0]  quo_q, quo_d, rmd_q, rmd_d;

  logic [W:0]    b_ext;
  logic [W:0]    rem_shift;
  logic [W:0]    diff;

  always_comb begin
    b_ext     = {din1[W-1], din1};
    rem_shift = {rem_q, dvd_q[W-1]};
    diff      = rem_shift - dsr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign0_d = din0[W-1];
            sign1_d = din1[W-1];
            zero_d  = (din1 == {din1_WIDTH{1'b0}});
            dvd_d   = din0[W-1] ? W'({(W+1){1'b0}} - {din0[W-1], din0}) : din0;
            dsr_d   = din1[W-1] ? ({(W+1){1'b0}} - b_ext) : b_ext;
            rem_d   = {W{1'b0}};
            cnt_d   = CW'(W);
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          // Borrow out of bit W means the trial subtraction is discarded.
          rem_d = diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
          dvd_d = {dvd_q[W-2:0], ~diff[W]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          // A zero divisor leaves all-ones in the quotient and |din0| in the
          // remainder, so restoring the dividend sign recovers din0 exactly.
          if (zero_q) begin
            quo_d = dvd_q;
          end else if (sign0_q ^ sign1_q) begin
            quo_d = {W{1'b0}} - dvd_q;
          end else begin
            quo_d = dvd_q;
          end
          rmd_d   = sign0_q ? ({W{1'b0}} - rem_q) : rem_q;
          dbz_d   = zero_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      rem_q   <= {W{1'b0}};
      dvd_q   <= {W{1'b0}};
      dsr_q   <= {(W+1){1'b0}};
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= {W{1'b0}};
      rmd_q   <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;

endmodule

// File: tb/tb_linear_image_filter_sdiv_seq.sv
// Bench for linear_image_filter_sdiv_seq: directed and random divisions
// checked against a 64-bit arithmetic reference model.
module tb_linear_image_filter_sdiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce;
  logic         start;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  linear_image_filter_sdiv_seq #(
    .din0_WIDTH(W),
    .din1_WIDTH(W),
    .dout_WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .start      (start),
    .din0       (din0),
    .din1       (din1),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Reference: C-style truncating division on 64-bit values.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      z  = 1'b0;
    end
  endtask

  // Launch one division and wait for done; lat counts edges from the accept edge.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input int stall_at, input int stall_len,
                        input bit poke,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat, output int done_cyc,
                        output int busy_errs);
    int edges;
    bit got;
    if (!b2b) @(negedge clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    ce    = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    busy_errs = 0;
    if (!busy) busy_errs++;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 200) begin
      ce = (edges >= stall_at && edges < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (poke && edges >= 3 && edges < 6) begin
        start = 1'b1;
        din0  = $urandom;
        din1  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      #1;
      if (done) begin
        got = 1'b1;
        if (busy) busy_errs++;
      end else if (!busy) begin
        busy_errs++;
      end
    end
    start    = 1'b0;
    ce       = 1'b1;
    lat      = got ? edges : -1;
    done_cyc = cyc;
    q        = quotient;
    r        = remainder;
    z        = div_by_zero;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = 32'd0;
    din1  = 32'd0;
    #2;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ce    = 1'b1;
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r;
    logic z;
    int lat, dc, be;
    do_div(32'd100, 32'd7, 1'b0, 0, 0, 1'b0, q, r, z, lat, dc, be);
    tests_run++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0", q, r, z);
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, want 33", lat);
    end
    tests_run++;
    if (be !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy: got %0d busy errors, want 0", be);
    end
  endtask

  task automatic test_signs;
    logic [W-1:0] a_t [3] = '{-32'sd100, 32'sd100, -32'sd100};
    logic [W-1:0] b_t [3] = '{32'sd7, -32'sd7, -32'sd7};
    logic [W-1:0] q_t [3] = '{-32'sd14, -32'sd14, 32'sd14};
    logic [W-1:0] r_t [3] = '{-32'sd2, 32'sd2, -32'sd2};
    logic [W-1:0] q, r;
    logic z;
    int lat, dc, be;
    for (int i = 0; i < 3; i++) begin
      do_div(a_t[i], b_t[i], 1'b0, 0, 0, 1'b0, q, r, z, lat, dc, be);
      tests_run++;
      if (q !== q_t[i] || r !== r_t[i] || z !== 1'b0 || lat !== 33) begin
        tests_failed++;
        $display("FAIL signs_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=33",
                 i, $signed(q), $signed(r), z, lat, $signed(q_t[i]), $signed(r_t[i]));
      end
    end
  endtask

  task automatic test_boundary;
    logic [W-1:0] q, r;
    logic z;
    int lat, dc, be;
    do_div(32'd5, 32'd0, 1'b0, 0, 0, 1'b0, q, r, z, lat, dc, be);
    tests_run++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1 || lat !== 33) begin
      tests_failed++;
      $display("FAIL div_zero: got q=%h r=%h dbz=%b lat=%0d, want q=ffffffff r=5 dbz=1 lat=33",
               q, r, z, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_outputs: got q=%h r=%h dbz=%b done=%b, want ffffffff 5 1 0",
               quotient, remainder, div_by_zero, done);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, q, r, z, lat, dc, be);
    tests_run++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0 || lat !== 33) begin
      tests_failed++;
      $display("FAIL min_by_m1: got q=%h r=%h dbz=%b lat=%0d, want 80000000 0 0 33", q, r, z, lat);
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] q, r;
    logic z;
    int lat, dc, be;
    do_div(32'd1000, 32'd10, 1'b0, 10, 10, 1'b1, q, r, z, lat, dc, be);
    tests_run++;
    if (q !== 32'd100 || r !== 32'd0 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_result: got q=%0d r=%0d dbz=%b, want 100 0 0", q, r, z);
    end
    tests_run++;
    if (lat !== 43) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d, want 43", lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat, dc, be;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom_range(1, 20);
        1: b = -$urandom_range(1, 300);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 3 == 0) a = a >> $urandom_range(0, 31);
      ref_div(a, b, eq, er, ez);
      do_div(a, b, 1'b0, 5 + (i % 7), i % 3, 1'b0, q, r, z, lat, dc, be);
      tests_run++;
      if (q !== eq || r !== er || z !== ez || lat !== 33 + (i % 3) || be !== 0) begin
        tests_failed++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b lat=%0d be=%0d, want q=%h r=%h dbz=%b lat=%0d",
                 i, a, b, q, r, z, lat, be, eq, er, ez, 33 + (i % 3));
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    din0  = 32'd100;
    din1  = 32'd7;
    start = 1'b1;
    ce    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    ce    = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    ce    = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_abort: got %0d cycles with done/busy after reset, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r;
    logic z;
    int lat, dc1, dc2, be;
    do_div(32'd7, 32'd2, 1'b0, 0, 0, 1'b0, q, r, z, lat, dc1, be);
    tests_run++;
    if (q !== 32'd3 || r !== 32'd1 || z !== 1'b0 || lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_first: got q=%0d r=%0d dbz=%b lat=%0d, want 3 1 0 33", q, r, z, lat);
    end
    do_div(-32'sd9, 32'd4, 1'b1, 0, 0, 1'b0, q, r, z, lat, dc2, be);
    tests_run++;
    if (q !== -32'sd2 || r !== -32'sd1 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: got q=%0d r=%0d dbz=%b, want -2 -1 0", $signed(q), $signed(r), z);
    end
    tests_run++;
    if (dc2 - dc1 !== 34) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 34", dc2 - dc1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_boundary();
    test_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
